cs_sample_feeder: RTL and testbench

//  Upstream sample source for the CS 9-tap series filter. The CS core shifts in X on every

---
 rtl/cs_sample_feeder.sv | 119 +++++++++++
 tb/tb_cs_sample_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_sample_feeder.sv
// Sample feeder for the CS 9-tap series filter: buffers bursty producer samples, primes a
// full window before streaming one sample per clock, and qualifies the returned CS result.
//
// state  | meaning
// IDLE   | FIFO flushed, waiting for the first sample
// PRIME  | filling FIFO up to PRIME_LVL, no pops
// STREAM | popping one sample to X every clock
module cs_sample_feeder #(
  parameter int DATA_W     = 8,
  parameter int Y_W        = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LVL  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] X,
  input  logic [Y_W-1:0]    Y,
  output logic [Y_W-1:0]    y_out,
  output logic              y_valid,
  output logic              underrun,
  output logic [4:0]        level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [4:0]    FULL_LVL = 5'(FIFO_DEPTH);
  localparam logic [4:0]    PRIME_L  = 5'(PRIME_LVL);
  localparam logic [3:0]    WIN_LEN  = 4'd9;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [3:0]        win_cnt;
  logic              x_real;
  logic              push;
  logic              pop;

  assign in_ready = reset && (level != FULL_LVL);
  assign push     = in_valid && in_ready && !clear;
  assign pop      = (state == STREAM) && (level != 5'd0);

  // Storage needs no reset; occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      X        <= '0;
      x_real   <= 1'b0;
      win_cnt  <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      underrun <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      x_real   <= 1'b0;
      win_cnt  <= '0;
      y_out    <= Y;
      y_valid  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // Y was produced on the previous edge from the window win_cnt described then.
      y_out   <= Y;
      y_valid <= (win_cnt == WIN_LEN);
      if (x_real) win_cnt <= (win_cnt == WIN_LEN) ? WIN_LEN : win_cnt + 4'd1;
      else        win_cnt <= '0;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase

      case (state)
        IDLE: begin
          x_real <= 1'b0;
          if (push) state <= PRIME;
        end
        PRIME: begin
          x_real <= 1'b0;
          if (level >= PRIME_L) state <= STREAM;
        end
        STREAM: begin
          if (pop) begin
            X      <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_ONE;
            x_real <= 1'b1;
          end else begin
            x_real   <= 1'b0;
            underrun <= 1'b1;
            state    <= PRIME;
          end
        end
        default: begin
          x_real <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_sample_feeder.sv
// Directed bench for cs_sample_feeder with a behavioural CS filter model driving Y.
module tb_cs_sample_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] X;
  logic [9:0] Y = '0;
  logic [9:0] y_out;
  logic       y_valid;
  logic       underrun;
  logic [4:0] level;

  // Second instance primes at full depth so the FIFO can actually fill.
  logic       b_clear = 1'b0;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_x;
  logic [9:0] b_y = '0;
  logic [9:0] b_yout;
  logic       b_yv;
  logic       b_un;
  logic [4:0] b_lvl;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cs_sample_feeder dut (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .X(X), .Y(Y), .y_out(y_out), .y_valid(y_valid),
    .underrun(underrun), .level(level)
  );

  cs_sample_feeder #(.PRIME_LVL(16)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .X(b_x), .Y(b_y), .y_out(b_yout), .y_valid(b_yv),
    .underrun(b_un), .level(b_lvl)
  );

  // CS model: 9-tap window, w[0] newest, w[8] oldest; Y = (sum + newest + 8*oldest) >> 3.
  logic [8:0][7:0] taps = '0;

  function automatic logic [9:0] cs_y(input logic [8:0][7:0] w);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(w[i]);
    s += int'(w[0]) + 8 * int'(w[8]);
    return 10'(s >> 3);
  endfunction

  always @(posedge clk) begin
    taps <= {taps[7:0], X};
    Y    <= cs_y({taps[7:0], X});
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       clr;
    logic [4:0] lvl;
    logic [7:0] x;
    logic       yv;
    logic       un;
    logic       chk_y;
    logic [9:0] y;
  } vec_t;

  vec_t tbl [23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Continuous pushes from level 0 in IDLE/PRIME: STREAM after 10 edges, first pop on edge 11.
  task automatic stream_run(input int base, input int n, input int exp_y);
    for (int e = 1; e <= n; e++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + e - 1);
      tick();
      chk($sformatf("run%0d level e%0d", base, e), int'(level), (e <= 9) ? e : 10);
      if (e >= 11) chk($sformatf("run%0d X e%0d", base, e), int'(X), base + e - 11);
      chk($sformatf("run%0d y_valid e%0d", base, e), int'(y_valid), (e >= 21) ? 1 : 0);
      if (e == 21) chk($sformatf("run%0d y_out", base), int'(y_out), exp_y);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    logic rdy;
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    b_valid  = 1'b0;
    b_data   = '0;

    for (int e = 1; e <= 23; e++) begin
      vec_t v;
      v = '{v: 0, d: 0, clr: 0, lvl: 0, x: 0, yv: 0, un: 0, chk_y: 0, y: 0};
      if (e <= 9) begin
        v.v = 1'b1; v.d = 8'd10; v.lvl = 5'(e);
      end else if (e == 10) begin
        v.lvl = 5'd9;
      end else if (e <= 19) begin
        v.lvl = 5'(19 - e); v.x = 8'd10;
      end else if (e <= 22) begin
        v.x = 8'd10; v.un = 1'b1;
        if (e == 21) begin v.yv = 1'b1; v.chk_y = 1'b1; v.y = 10'd22; end
      end else begin
        v.clr = 1'b1; v.x = 8'd10;
      end
      tbl[e-1] = v;
    end

    #7;
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset level", int'(level), 0);
    chk("reset X", int'(X), 0);
    chk("reset y_out", int'(y_out), 0);
    chk("reset y_valid", int'(y_valid), 0);
    chk("reset underrun", int'(underrun), 0);
    #5 reset = 1'b1;
    #1;
    chk("post-reset in_ready", int'(in_ready), 1);

    // Nine 10s, stream, run dry, then clear.
    for (int i = 0; i < 23; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      clear    = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d level", i + 1), int'(level), int'(tbl[i].lvl));
      chk($sformatf("tbl%0d in_ready", i + 1), int'(in_ready), (tbl[i].lvl != 5'd16) ? 1 : 0);
      chk($sformatf("tbl%0d X", i + 1), int'(X), int'(tbl[i].x));
      chk($sformatf("tbl%0d y_valid", i + 1), int'(y_valid), int'(tbl[i].yv));
      chk($sformatf("tbl%0d underrun", i + 1), int'(underrun), int'(tbl[i].un));
      if (tbl[i].chk_y) chk($sformatf("tbl%0d y_out", i + 1), int'(y_out), int'(tbl[i].y));
    end
    clear    = 1'b0;
    in_valid = 1'b0;

    // Prime stall at 8, then the 9th push.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      chk($sformatf("prime level %0d", i), int'(level), i);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall level", int'(level), 8);
      chk("stall X", int'(X), 10);
      chk("stall y_valid", int'(y_valid), 0);
    end
    in_valid = 1'b1; in_data = 8'd9;
    tick();
    in_valid = 1'b0;
    chk("9th push level", int'(level), 9);
    tick();
    chk("enter stream level", int'(level), 9);
    chk("enter stream X", int'(X), 10);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("pop X %0d", i), int'(X), i);
      chk($sformatf("pop level %0d", i), int'(level), 9 - i);
      chk($sformatf("pop y_valid %0d", i), int'(y_valid), 0);
    end
    tick();
    chk("dry X held", int'(X), 9);
    chk("dry underrun", int'(underrun), 1);
    chk("dry y_valid", int'(y_valid), 0);
    tick();
    chk("dry+1 y_valid", int'(y_valid), 1);
    chk("dry+1 y_out", int'(y_out), 7);
    tick();
    chk("bubble y_valid falls", int'(y_valid), 0);

    // Re-prime after underrun: validity needs 9 fresh pops.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("reprime level", int'(level), 9);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("repop X %0d", i), int'(X), 20 + i);
      chk($sformatf("repop y_valid %0d", i), int'(y_valid), 0);
    end
    tick();
    chk("repop+1 y_valid", int'(y_valid), 0);
    tick();
    chk("repop+2 y_valid", int'(y_valid), 1);
    chk("repop+2 y_out", int'(y_out), 50);
    tick();

    // Clear with a simultaneous push mid-stream.
    stream_run(40, 25, 95);
    chk("pre-clear underrun sticky", int'(underrun), 1);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear level", int'(level), 0);
    chk("clear y_valid", int'(y_valid), 0);
    chk("clear underrun", int'(underrun), 0);
    chk("clear X held", int'(X), 54);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle level", int'(level), 0);
      chk("idle underrun", int'(underrun), 0);
    end
    stream_run(60, 25, 140);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    chk("async X", int'(X), 0);
    chk("async y_out", int'(y_out), 0);
    chk("async level", int'(level), 0);
    chk("async y_valid", int'(y_valid), 0);
    chk("async underrun", int'(underrun), 0);
    chk("async in_ready", int'(in_ready), 0);
    #1 reset = 1'b1;
    stream_run(70, 22, 163);
    chk("post-reset underrun", int'(underrun), 0);

    // Fill to depth 16 with a producer that holds data while in_ready is low.
    cur = 100;
    b_valid = 1'b1; b_data = 8'(cur);
    for (int e = 1; e <= 34; e++) begin
      rdy = b_ready;
      tick();
      if (rdy && b_valid) cur++;
      b_valid = (cur <= 116);
      b_data  = 8'(cur);
      if (e == 16) begin
        chk("full level", int'(b_lvl), 16);
        chk("full in_ready", int'(b_ready), 0);
      end
      if (e == 17) begin
        chk("full held level", int'(b_lvl), 16);
        chk("full held sample", cur, 116);
      end
      if (e >= 18) chk($sformatf("full order X e%0d", e), int'(b_x), 100 + e - 18);
    end
    chk("full all accepted", cur, 117);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
